// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between IFU and IF/ID: circular buffer with count,
// flush, and a trap hold that freezes fetch once a faulting entry is queued.
`ifndef TRAP_LEN
`define TRAP_LEN 3
`endif

package inst_fetch_queue_pkg;
   localparam int unsigned TW = `TRAP_LEN;

   typedef struct packed {
      logic [31:0]   pc;
      logic [31:0]   inst;
      logic [TW-1:0] trap;
      logic          pdt_taken;
      logic [31:0]   pdt_pc;
   } ifq_entry_t;
endpackage

module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enq_valid_i,
   output logic                    enq_ready_o,
   input  logic [31:0]             enq_pc_i,
   input  logic [31:0]             enq_inst_i,
   input  logic [`TRAP_LEN-1:0]    enq_trap_i,
   input  logic                    enq_pdt_taken_i,
   input  logic [31:0]             enq_pdt_pc_i,
   input  logic                    flush_i,
   output logic                    deq_valid_o,
   input  logic                    deq_ready_i,
   output logic [31:0]             deq_pc_o,
   output logic [31:0]             deq_inst_o,
   output logic [`TRAP_LEN-1:0]    deq_trap_o,
   output logic                    deq_pdt_taken_o,
   output logic [31:0]             deq_pdt_pc_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    trap_hold_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   ifq_entry_t      mem_q [DEPTH];
   ifq_entry_t      enq_ent;
   ifq_entry_t      head_ent;
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            trap_hold_q, trap_hold_d;
   logic            enq_fire;
   logic            deq_fire;

   // Handshakes depend only on registered state and flush, never on the peer side.
   always_comb begin
      enq_ready_o = (count_q < CW'(DEPTH)) && !flush_i && !trap_hold_q;
      deq_valid_o = (count_q != '0) && !flush_i;
      enq_fire    = enq_valid_i && enq_ready_o;
      deq_fire    = deq_valid_o && deq_ready_i;
   end

   always_comb begin
      enq_ent.pc        = enq_pc_i;
      enq_ent.inst      = enq_inst_i;
      enq_ent.trap      = enq_trap_i;
      enq_ent.pdt_taken = enq_pdt_taken_i;
      enq_ent.pdt_pc    = enq_pdt_pc_i;
   end

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      trap_hold_d = trap_hold_q;
      if (flush_i) begin
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         trap_hold_d = 1'b0;
      end else begin
         if (enq_fire) begin
            tail_d = tail_q + AW'(1);
            if (|enq_trap_i) trap_hold_d = 1'b1;
         end
         if (deq_fire) head_d = head_q + AW'(1);
         if (enq_fire && !deq_fire)      count_d = count_q + CW'(1);
         else if (!enq_fire && deq_fire) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         trap_hold_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         trap_hold_q <= trap_hold_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (enq_fire) begin
         mem_q[tail_q] <= enq_ent;
      end
   end

   // Empty queue presents an all-zero head.
   always_comb begin
      head_ent = (count_q != '0) ? mem_q[head_q] : '0;
   end

   assign deq_pc_o        = head_ent.pc;
   assign deq_inst_o      = head_ent.inst;
   assign deq_trap_o      = head_ent.trap;
   assign deq_pdt_taken_o = head_ent.pdt_taken;
   assign deq_pdt_pc_o    = head_ent.pdt_pc;
   assign count_o         = count_q;
   assign trap_hold_o     = trap_hold_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table, corner-case
// sequences, and random traffic against a queue-based reference model.
`ifndef TRAP_LEN
`define TRAP_LEN 3
`endif

module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enq_valid, enq_ready;
   logic [31:0]       enq_pc, enq_inst, enq_pdt_pc;
   logic [TW-1:0]     enq_trap;
   logic              enq_pdt_taken;
   logic              flush;
   logic              deq_valid, deq_ready;
   logic [31:0]       deq_pc, deq_inst, deq_pdt_pc;
   logic [TW-1:0]     deq_trap;
   logic              deq_pdt_taken;
   logic [CW-1:0]     count;
   logic              trap_hold;

   int checks = 0;
   int errors = 0;

   ifq_entry_t mq[$];
   bit         mhold = 1'b0;

   typedef struct {
      bit          ev;
      logic [31:0] pc;
      bit          dr;
      bit          exp_valid;
      bit          exp_ready;
      int          exp_count;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vt[14];

   inst_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
      .enq_pc_i(enq_pc), .enq_inst_i(enq_inst), .enq_trap_i(enq_trap),
      .enq_pdt_taken_i(enq_pdt_taken), .enq_pdt_pc_i(enq_pdt_pc),
      .flush_i(flush),
      .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
      .deq_pc_o(deq_pc), .deq_inst_o(deq_inst), .deq_trap_o(deq_trap),
      .deq_pdt_taken_o(deq_pdt_taken), .deq_pdt_pc_o(deq_pdt_pc),
      .count_o(count), .trap_hold_o(trap_hold)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit ev, input logic [31:0] pc, input logic [TW-1:0] trap,
                        input bit dr, input bit fl);
      enq_valid     = ev;
      enq_pc        = pc;
      enq_inst      = pc ^ 32'h0000_0013;
      enq_trap      = trap;
      enq_pdt_taken = pc[2];
      enq_pdt_pc    = pc + 32'd8;
      deq_ready     = dr;
      flush         = fl;
   endtask

   // Compare every output against the reference model; call at negedge.
   task automatic check_model();
      ifq_entry_t e;
      bit m_ready, m_valid;
      m_ready = (mq.size() < int'(DEPTH)) && !flush && !mhold;
      m_valid = (mq.size() != 0) && !flush;
      e = (mq.size() != 0) ? mq[0] : '0;
      chk("m_deq_valid", 64'(deq_valid), 64'(m_valid));
      chk("m_enq_ready", 64'(enq_ready), 64'(m_ready));
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_trap_hold", 64'(trap_hold), 64'(mhold));
      chk("m_deq_pc", 64'(deq_pc), 64'(e.pc));
      chk("m_deq_inst", 64'(deq_inst), 64'(e.inst));
      chk("m_deq_trap", 64'(deq_trap), 64'(e.trap));
      chk("m_deq_pdt_taken", 64'(deq_pdt_taken), 64'(e.pdt_taken));
      chk("m_deq_pdt_pc", 64'(deq_pdt_pc), 64'(e.pdt_pc));
   endtask

   // Advance model and DUT across one rising edge; inputs change at edge+1.
   task automatic advance();
      ifq_entry_t e;
      bit m_enq, m_deq;
      m_enq = enq_valid && (mq.size() < int'(DEPTH)) && !flush && !mhold;
      m_deq = deq_ready && (mq.size() != 0) && !flush;
      e.pc = enq_pc; e.inst = enq_inst; e.trap = enq_trap;
      e.pdt_taken = enq_pdt_taken; e.pdt_pc = enq_pdt_pc;
      @(posedge clk);
      if (flush) begin
         mq.delete();
         mhold = 1'b0;
      end else begin
         if (m_deq) void'(mq.pop_front());
         if (m_enq) begin
            mq.push_back(e);
            if (|e.trap) mhold = 1'b1;
         end
      end
      #1;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_model();
      advance();
   endtask

   function automatic vec_t mkv(bit ev, logic [31:0] pc, bit dr, bit v, bit r, int c, logic [31:0] hp);
      vec_t x;
      x.ev = ev; x.pc = pc; x.dr = dr;
      x.exp_valid = v; x.exp_ready = r; x.exp_count = c; x.exp_pc = hp;
      return x;
   endfunction

   initial begin
      // single-entry latency, then fill to full with a blocked 5th enqueue
      vt[0]  = mkv(1, 32'h8000_0000, 1, 0, 1, 0, 32'h0);
      vt[1]  = mkv(0, 32'h0,         1, 1, 1, 1, 32'h8000_0000);
      vt[2]  = mkv(0, 32'h0,         0, 0, 1, 0, 32'h0);
      vt[3]  = mkv(1, 32'h100,       0, 0, 1, 0, 32'h0);
      vt[4]  = mkv(1, 32'h104,       0, 1, 1, 1, 32'h100);
      vt[5]  = mkv(1, 32'h108,       0, 1, 1, 2, 32'h100);
      vt[6]  = mkv(1, 32'h10C,       0, 1, 1, 3, 32'h100);
      vt[7]  = mkv(1, 32'h110,       0, 1, 0, 4, 32'h100);
      vt[8]  = mkv(1, 32'h110,       1, 1, 0, 4, 32'h100);
      vt[9]  = mkv(1, 32'h110,       1, 1, 1, 3, 32'h104);
      vt[10] = mkv(0, 32'h0,         1, 1, 1, 3, 32'h108);
      vt[11] = mkv(0, 32'h0,         1, 1, 1, 2, 32'h10C);
      vt[12] = mkv(0, 32'h0,         1, 1, 1, 1, 32'h110);
      vt[13] = mkv(0, 32'h0,         1, 0, 1, 0, 32'h0);

      rst_n = 1'b0;
      drive(0, 32'h0, '0, 0, 0);
      #12;
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_deq_valid", 64'(deq_valid), 64'(0));
      chk("rst_enq_ready", 64'(enq_ready), 64'(1));
      chk("rst_trap_hold", 64'(trap_hold), 64'(0));
      chk("rst_deq_pc", 64'(deq_pc), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         drive(vt[i].ev, vt[i].pc, '0, vt[i].dr, 0);
         if (vt[i].pc == 32'h8000_0000) enq_inst = 32'h0000_0013;
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), 64'(deq_valid), 64'(vt[i].exp_valid));
         chk($sformatf("vec%0d_ready", i), 64'(enq_ready), 64'(vt[i].exp_ready));
         chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].exp_count));
         chk($sformatf("vec%0d_pc", i), 64'(deq_pc), 64'(vt[i].exp_pc));
         if (i == 1) chk("vec1_inst", 64'(deq_inst), 64'(32'h0000_0013));
         check_model();
         advance();
      end

      // steady simultaneous enq/deq at count 2 wraps the pointers
      drive(1, 32'h300, '0, 0, 0); cycle();
      drive(1, 32'h304, '0, 0, 0); cycle();
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h308 + 32'(4 * i), '0, 1, 0);
         @(negedge clk);
         chk("wrap_count", 64'(count), 64'(2));
         chk("wrap_order", 64'(deq_pc), 64'(32'h300 + 32'(4 * i)));
         check_model();
         advance();
      end
      drive(0, 32'h0, '0, 0, 1); cycle();

      // flush with count 3 and an enqueue offered
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h400 + 32'(4 * i), '0, 0, 0); cycle();
      end
      drive(1, 32'h40C, '0, 1, 1);
      @(negedge clk);
      chk("flush_deq_valid", 64'(deq_valid), 64'(0));
      chk("flush_enq_ready", 64'(enq_ready), 64'(0));
      check_model();
      advance();
      drive(0, 32'h0, '0, 1, 0);
      @(negedge clk);
      chk("flush_count", 64'(count), 64'(0));
      check_model();
      advance();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_no_stale", 64'(deq_valid), 64'(0));
         advance();
      end

      // trap hold: page fault entry freezes fetch until flush
      drive(1, 32'h200, TW'(3'b100), 0, 0); cycle();
      drive(1, 32'h204, '0, 0, 0);
      @(negedge clk);
      chk("trap_hold_set", 64'(trap_hold), 64'(1));
      chk("trap_enq_ready", 64'(enq_ready), 64'(0));
      check_model();
      advance();
      drive(1, 32'h208, '0, 1, 0);
      @(negedge clk);
      chk("trap_deq_pc", 64'(deq_pc), 64'(32'h200));
      chk("trap_deq_bits", 64'(deq_trap), 64'(TW'(3'b100)));
      check_model();
      advance();
      drive(1, 32'h20C, '0, 1, 0);
      @(negedge clk);
      chk("trap_hold_persist", 64'(trap_hold), 64'(1));
      chk("trap_frozen", 64'(enq_ready), 64'(0));
      check_model();
      advance();
      drive(0, 32'h0, '0, 0, 1); cycle();
      drive(0, 32'h0, '0, 0, 0);
      @(negedge clk);
      chk("trap_hold_clear", 64'(trap_hold), 64'(0));
      chk("trap_ready_back", 64'(enq_ready), 64'(1));
      check_model();
      advance();

      // asynchronous reset mid-cycle with count 3
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h500 + 32'(4 * i), '0, 0, 0); cycle();
      end
      drive(0, 32'h0, '0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count", 64'(count), 64'(0));
      chk("arst_deq_valid", 64'(deq_valid), 64'(0));
      chk("arst_deq_pc", 64'(deq_pc), 64'(0));
      chk("arst_enq_ready", 64'(enq_ready), 64'(1));
      mq.delete();
      mhold = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1, 32'h600, '0, 0, 0); cycle();
      drive(0, 32'h0, '0, 1, 0);
      @(negedge clk);
      chk("arst_first_enq", 64'(deq_pc), 64'(32'h600));
      check_model();
      advance();

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         enq_valid     = ($urandom % 4) != 0;
         enq_pc        = $urandom;
         enq_inst      = $urandom;
         enq_trap      = (($urandom % 16) == 0) ? TW'($urandom_range(1, (1 << TW) - 1)) : '0;
         enq_pdt_taken = 1'($urandom);
         enq_pdt_pc    = $urandom;
         deq_ready     = ($urandom % 3) != 0;
         flush         = ($urandom % 25) == 0;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
